// File: rtl/spi7001_rx_decoder.sv
// spi7001_rx_decoder: receiver for the SPI7001 DCLK/SDI/LE/scan pins.
// Oversamples the pins in the I_clk domain, rebuilds grayscale words,
// decodes LE-width commands and gathers full latch groups with their scan row.
module spi7001_rx_decoder #(
  parameter int WORD_W          = 16,
  parameter int WORDS_PER_LATCH = 6,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                              I_clk,
  input  logic                              I_rst,
  input  logic                              I_dclk,
  input  logic                              I_sdi,
  input  logic                              I_le,
  input  logic [3:0]                        I_scan,
  output logic                              O_word_valid,
  output logic [WORD_W-1:0]                 O_word_data,
  output logic [2:0]                        O_word_idx,
  output logic                              O_latch_valid,
  output logic [WORD_W*WORDS_PER_LATCH-1:0] O_latch_data,
  output logic [1:0]                        O_latch_row,
  output logic                              O_vsync,
  output logic                              O_cmd_valid,
  output logic [3:0]                        O_cmd_code,
  output logic                              O_err
);

  localparam int         LATCH_W   = WORD_W * WORDS_PER_LATCH;
  localparam int         LAST      = SYNC_STAGES - 1;
  localparam logic [2:0] LAST_IDX  = 3'(WORDS_PER_LATCH - 1);
  localparam logic [4:0] FULL_BITS = 5'(WORD_W);

  // Pin synchronizers, edge-detect delay flops and the post-reset priming chain
  logic [SYNC_STAGES-1:0] dclk_sync_q, dclk_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic [SYNC_STAGES-1:0] le_sync_q, le_sync_d;
  logic [3:0]             scan_sync_q [SYNC_STAGES];
  logic [3:0]             scan_sync_d [SYNC_STAGES];
  logic [SYNC_STAGES:0]   primed_q, primed_d;
  logic                   dclk_dly_q, dclk_dly_d;
  logic                   sdi_dly_q, sdi_dly_d;
  logic                   le_dly_q, le_dly_d;
  logic                   dclk_rise_q, dclk_rise_d;
  logic                   le_rise_q, le_rise_d;
  logic                   le_fall_q, le_fall_d;

  // Serial assembly, LE decode state and word slots
  logic [WORD_W-1:0]      shift_q, shift_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [3:0]             le_cnt_q, le_cnt_d;
  logic                   le_armed_q, le_armed_d;
  logic [2:0]             group_idx_q, group_idx_d;
  logic [WORD_W-1:0]      slot_q [WORDS_PER_LATCH];
  logic [WORD_W-1:0]      slot_d [WORDS_PER_LATCH];

  // Registered outputs
  logic                   word_valid_q, word_valid_d;
  logic [WORD_W-1:0]      word_data_q, word_data_d;
  logic [2:0]             word_idx_q, word_idx_d;
  logic                   latch_valid_q, latch_valid_d;
  logic [LATCH_W-1:0]     latch_data_q, latch_data_d;
  logic [1:0]             latch_row_q, latch_row_d;
  logic                   vsync_q, vsync_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [3:0]             cmd_code_q, cmd_code_d;
  logic                   err_q, err_d;

  // Sample the pins and flag edges; edges stay masked until the sync chain and
  // delay flop hold real pin values, so a level present at reset release is not an edge
  always_comb begin
    dclk_sync_d    = {dclk_sync_q[SYNC_STAGES-2:0], I_dclk};
    sdi_sync_d     = {sdi_sync_q[SYNC_STAGES-2:0], I_sdi};
    le_sync_d      = {le_sync_q[SYNC_STAGES-2:0], I_le};
    scan_sync_d[0] = I_scan;
    for (int i = 1; i < SYNC_STAGES; i++) scan_sync_d[i] = scan_sync_q[i-1];
    primed_d       = {primed_q[SYNC_STAGES-1:0], 1'b1};
    dclk_dly_d     = dclk_sync_q[LAST];
    sdi_dly_d      = sdi_sync_q[LAST];
    le_dly_d       = le_sync_q[LAST];
    dclk_rise_d    = primed_q[SYNC_STAGES] & dclk_sync_q[LAST] & ~dclk_dly_q;
    le_rise_d      = primed_q[SYNC_STAGES] & le_sync_q[LAST] & ~le_dly_q;
    le_fall_d      = primed_q[SYNC_STAGES] & ~le_sync_q[LAST] & le_dly_q;
  end

  // Shift/count on DCLK rise first, then decode an armed LE fall from the updated counts
  always_comb begin
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    le_cnt_d      = le_cnt_q;
    le_armed_d    = le_armed_q;
    group_idx_d   = group_idx_q;
    slot_d        = slot_q;
    word_valid_d  = 1'b0;
    word_data_d   = word_data_q;
    word_idx_d    = word_idx_q;
    latch_valid_d = 1'b0;
    latch_data_d  = latch_data_q;
    latch_row_d   = latch_row_q;
    vsync_d       = 1'b0;
    cmd_valid_d   = 1'b0;
    cmd_code_d    = cmd_code_q;
    err_d         = 1'b0;

    if (dclk_rise_q) begin
      shift_d = {shift_q[WORD_W-2:0], sdi_dly_q};
      if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
      if (le_dly_q && (le_cnt_q != 4'd15)) le_cnt_d = le_cnt_q + 4'd1;
    end

    if (le_rise_q) le_armed_d = 1'b1;

    if (le_fall_q && le_armed_q) begin
      case (le_cnt_d)
        4'd0: err_d = 1'b1;
        4'd1: begin
          if (bit_cnt_d != FULL_BITS) begin
            err_d = 1'b1;
          end else begin
            word_valid_d         = 1'b1;
            word_data_d          = shift_d;
            word_idx_d           = group_idx_q;
            slot_d[group_idx_q]  = shift_d;
            if (group_idx_q == LAST_IDX) begin
              latch_valid_d = 1'b1;
              for (int i = 0; i < WORDS_PER_LATCH; i++)
                latch_data_d[LATCH_W-1-i*WORD_W -: WORD_W] = slot_d[i];
              group_idx_d = 3'd0;
              case (scan_sync_q[LAST])
                4'b0001: latch_row_d = 2'd0;
                4'b0010: latch_row_d = 2'd1;
                4'b0100: latch_row_d = 2'd2;
                4'b1000: latch_row_d = 2'd3;
                default: begin
                  latch_row_d = 2'd0;
                  err_d       = 1'b1;
                end
              endcase
            end else begin
              group_idx_d = group_idx_q + 3'd1;
            end
          end
        end
        4'd2: begin
          vsync_d     = 1'b1;
          group_idx_d = 3'd0;
        end
        default: begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = le_cnt_d;
        end
      endcase
      le_armed_d = 1'b0;
      bit_cnt_d  = 5'd0;
      le_cnt_d   = 4'd0;
    end
  end

  // State and output registers; reset drops every partial word and group
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      dclk_sync_q   <= '0;
      sdi_sync_q    <= '0;
      le_sync_q     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) scan_sync_q[i] <= '0;
      primed_q      <= '0;
      dclk_dly_q    <= 1'b0;
      sdi_dly_q     <= 1'b0;
      le_dly_q      <= 1'b0;
      dclk_rise_q   <= 1'b0;
      le_rise_q     <= 1'b0;
      le_fall_q     <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      le_cnt_q      <= '0;
      le_armed_q    <= 1'b0;
      group_idx_q   <= '0;
      for (int i = 0; i < WORDS_PER_LATCH; i++) slot_q[i] <= '0;
      word_valid_q  <= 1'b0;
      word_data_q   <= '0;
      word_idx_q    <= '0;
      latch_valid_q <= 1'b0;
      latch_data_q  <= '0;
      latch_row_q   <= '0;
      vsync_q       <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      dclk_sync_q   <= dclk_sync_d;
      sdi_sync_q    <= sdi_sync_d;
      le_sync_q     <= le_sync_d;
      scan_sync_q   <= scan_sync_d;
      primed_q      <= primed_d;
      dclk_dly_q    <= dclk_dly_d;
      sdi_dly_q     <= sdi_dly_d;
      le_dly_q      <= le_dly_d;
      dclk_rise_q   <= dclk_rise_d;
      le_rise_q     <= le_rise_d;
      le_fall_q     <= le_fall_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      le_cnt_q      <= le_cnt_d;
      le_armed_q    <= le_armed_d;
      group_idx_q   <= group_idx_d;
      slot_q        <= slot_d;
      word_valid_q  <= word_valid_d;
      word_data_q   <= word_data_d;
      word_idx_q    <= word_idx_d;
      latch_valid_q <= latch_valid_d;
      latch_data_q  <= latch_data_d;
      latch_row_q   <= latch_row_d;
      vsync_q       <= vsync_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      err_q         <= err_d;
    end
  end

  assign O_word_valid  = word_valid_q;
  assign O_word_data   = word_data_q;
  assign O_word_idx    = word_idx_q;
  assign O_latch_valid = latch_valid_q;
  assign O_latch_data  = latch_data_q;
  assign O_latch_row   = latch_row_q;
  assign O_vsync       = vsync_q;
  assign O_cmd_valid   = cmd_valid_q;
  assign O_cmd_code    = cmd_code_q;
  assign O_err         = err_q;

endmodule

// File: tb/tb_spi7001_rx_decoder.sv
// tb_spi7001_rx_decoder: drives SPI7001 pin transactions into the receiver and
// compares every output pulse with a transaction-level model of the protocol.
module tb_spi7001_rx_decoder;

  typedef struct packed {
    logic        wv;
    logic [15:0] wd;
    logic [2:0]  widx;
    logic        lv;
    logic [95:0] ld;
    logic [1:0]  row;
    logic        vs;
    logic        cv;
    logic [3:0]  cc;
    logic        err;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        dclk;
  logic        sdi;
  logic        le;
  logic [3:0]  scan;
  logic        word_valid;
  logic [15:0] word_data;
  logic [2:0]  word_idx;
  logic        latch_valid;
  logic [95:0] latch_data;
  logic [1:0]  latch_row;
  logic        vsync;
  logic        cmd_valid;
  logic [3:0]  cmd_code;
  logic        err;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  ev_t         ev_q[$];
  int          evcyc_q[$];
  ev_t         mon_e;

  int          m_idx;
  logic [15:0] m_slots [6];

  spi7001_rx_decoder dut (
    .I_clk         (clk),
    .I_rst         (rst),
    .I_dclk        (dclk),
    .I_sdi         (sdi),
    .I_le          (le),
    .I_scan        (scan),
    .O_word_valid  (word_valid),
    .O_word_data   (word_data),
    .O_word_idx    (word_idx),
    .O_latch_valid (latch_valid),
    .O_latch_data  (latch_data),
    .O_latch_row   (latch_row),
    .O_vsync       (vsync),
    .O_cmd_valid   (cmd_valid),
    .O_cmd_code    (cmd_code),
    .O_err         (err)
  );

  // 50 MHz system clock
  always #10 clk = ~clk;

  // Cycle counter used to time-stamp output pulses
  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle carrying a pulse; data fields kept only with their own pulse
  always @(negedge clk) begin
    if (!rst && (word_valid || latch_valid || vsync || cmd_valid || err)) begin
      mon_e      = '0;
      mon_e.wv   = word_valid;
      mon_e.wd   = word_valid ? word_data : 16'h0;
      mon_e.widx = word_valid ? word_idx : 3'd0;
      mon_e.lv   = latch_valid;
      mon_e.ld   = latch_valid ? latch_data : 96'h0;
      mon_e.row  = latch_valid ? latch_row : 2'd0;
      mon_e.vs   = vsync;
      mon_e.cv   = cmd_valid;
      mon_e.cc   = cmd_valid ? cmd_code : 4'd0;
      mon_e.err  = err;
      ev_q.push_back(mon_e);
      evcyc_q.push_back(cyc);
    end
  end

  // Protocol model: one LE pulse with a given width after a given bit count
  task automatic model_step(input logic [63:0] bits, input int total, input int le_w,
                            output ev_t exp);
    logic bad;
    exp = '0;
    if (le_w == 0) begin
      exp.err = 1'b1;
    end else if (le_w == 1) begin
      if (total != 16) begin
        exp.err = 1'b1;
      end else begin
        exp.wv          = 1'b1;
        exp.wd          = bits[15:0];
        exp.widx        = 3'(m_idx);
        m_slots[m_idx]  = bits[15:0];
        if (m_idx == 5) begin
          exp.lv  = 1'b1;
          exp.ld  = {m_slots[0], m_slots[1], m_slots[2], m_slots[3], m_slots[4], m_slots[5]};
          exp.row = 2'd0;
          bad     = 1'b1;
          for (int k = 0; k < 4; k++)
            if (scan == 4'(1 << k)) begin
              exp.row = 2'(k);
              bad     = 1'b0;
            end
          if (bad) exp.err = 1'b1;
          m_idx = 0;
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end else if (le_w == 2) begin
      exp.vs = 1'b1;
      m_idx  = 0;
    end else begin
      exp.cv = 1'b1;
      exp.cc = (le_w > 15) ? 4'd15 : 4'(le_w);
    end
  endtask

  // Drive one transaction: total bits MSB first, LE high for the last le_w DCLK rises
  task automatic xfer(input logic [63:0] bits, input int total, input int le_w,
                      output int n, output ev_t obs, output int lat);
    int fall;
    ev_q.delete();
    evcyc_q.delete();
    for (int i = 0; i < total; i++) begin
      sdi = bits[total-1-i];
      le  = (i >= total - le_w);
      repeat (3) @(negedge clk);
      dclk = 1'b1;
      repeat (3) @(negedge clk);
      dclk = 1'b0;
    end
    if (le_w == 0) begin
      le = 1'b1;
      repeat (4) @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
    end
    le   = 1'b0;
    fall = cyc;
    repeat (10) @(negedge clk);
    n   = ev_q.size();
    obs = (n > 0) ? ev_q[0] : '0;
    lat = (n > 0) ? evcyc_q[0] - fall : -1;
  endtask

  // Reset values, both while held and just after release
  task automatic test_reset();
    rst  = 1'b1;
    dclk = 1'b0;
    sdi  = 1'b0;
    le   = 1'b0;
    scan = 4'b0100;
    m_idx = 0;
    for (int k = 0; k < 6; k++) m_slots[k] = 16'h0;
    repeat (4) @(negedge clk);
    checks++;
    if ({word_valid, word_data, word_idx, latch_valid, latch_data, latch_row,
         vsync, cmd_valid, cmd_code, err} !== 126'h0) begin
      failures++;
      $display("[TB] FAIL reset_held: got %h expected 0", {word_valid, word_data, word_idx,
               latch_valid, latch_data, latch_row, vsync, cmd_valid, cmd_code, err});
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if ({word_valid, word_data, word_idx, latch_valid, latch_row, vsync, cmd_valid,
         cmd_code, err} !== 30'h0) begin
      failures++;
      $display("[TB] FAIL reset_released: got %h expected 0", {word_valid, word_data,
               word_idx, latch_valid, latch_row, vsync, cmd_valid, cmd_code, err});
    end
    checks++;
    if (latch_data !== 96'h0) begin
      failures++;
      $display("[TB] FAIL reset_latch_data: got %h expected 0", latch_data);
    end
  endtask

  // Full group of six known words on row 2
  task automatic test_group();
    logic [15:0] words [6] = '{16'h0001, 16'h00FF, 16'h1234, 16'h8000, 16'hFFFF, 16'hA5A5};
    ev_t exp, obs;
    int  n, lat;
    for (int i = 0; i < 6; i++) begin
      model_step({48'h0, words[i]}, 16, 1, exp);
      xfer({48'h0, words[i]}, 16, 1, n, obs, lat);
      checks++;
      if (n !== 1) begin failures++; $display("[TB] FAIL group_count: got %0d expected 1", n); end
      checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL group_event: got %h expected %h", obs, exp); end
      checks++;
      if (lat !== 4) begin failures++; $display("[TB] FAIL group_latency: got %0d expected 4", lat); end
    end
    checks++;
    if (obs.ld !== 96'h000100FF12348000FFFFA5A5 || obs.row !== 2'd2 || obs.lv !== 1'b1) begin
      failures++;
      $display("[TB] FAIL group_latch: got %h row %0d lv %b expected 000100ff12348000ffffa5a5 row 2 lv 1",
               obs.ld, obs.row, obs.lv);
    end
  endtask

  // Short word is an error and leaves the group position alone
  task automatic test_short_word();
    logic [63:0] b [4];
    int          tot [4] = '{16, 16, 15, 16};
    ev_t exp, obs;
    int  n, lat;
    for (int i = 0; i < 4; i++) begin
      b[i] = {$urandom, $urandom};
      model_step(b[i], tot[i], 1, exp);
      xfer(b[i], tot[i], 1, n, obs, lat);
      checks++;
      if (n !== 1) begin failures++; $display("[TB] FAIL short_count: got %0d expected 1", n); end
      checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL short_event: got %h expected %h", obs, exp); end
      checks++;
      if (lat !== 4) begin failures++; $display("[TB] FAIL short_latency: got %0d expected 4", lat); end
    end
    checks++;
    if (obs.widx !== 3'd2 || obs.wv !== 1'b1) begin
      failures++;
      $display("[TB] FAIL short_next_idx: got idx %0d wv %b expected idx 2 wv 1", obs.widx, obs.wv);
    end
  endtask

  // Vsync discards a partial group and restarts at slot 0
  task automatic test_vsync();
    int  tot [5] = '{16, 16, 16, 2, 16};
    int  lw  [5] = '{1, 1, 1, 2, 1};
    logic [63:0] b;
    ev_t exp, obs;
    int  n, lat;
    for (int i = 0; i < 5; i++) begin
      b = {$urandom, $urandom};
      model_step(b, tot[i], lw[i], exp);
      xfer(b, tot[i], lw[i], n, obs, lat);
      checks++;
      if (n !== 1) begin failures++; $display("[TB] FAIL vsync_count: got %0d expected 1", n); end
      checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL vsync_event: got %h expected %h", obs, exp); end
      checks++;
      if (lat !== 4) begin failures++; $display("[TB] FAIL vsync_latency: got %0d expected 4", lat); end
    end
    checks++;
    if (obs.widx !== 3'd0) begin
      failures++;
      $display("[TB] FAIL vsync_next_idx: got %0d expected 0", obs.widx);
    end
  endtask

  // Commands: width 5 after 48 bits, saturated width, and an LE pulse with no DCLK
  task automatic test_cmd();
    int  tot [3] = '{53, 17, 0};
    int  lw  [3] = '{5, 17, 0};
    logic [63:0] b;
    ev_t exp, obs;
    int  n, lat;
    for (int i = 0; i < 3; i++) begin
      b = {$urandom, $urandom};
      model_step(b, tot[i], lw[i], exp);
      xfer(b, tot[i], lw[i], n, obs, lat);
      checks++;
      if (n !== 1) begin failures++; $display("[TB] FAIL cmd_count: got %0d expected 1", n); end
      checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL cmd_event: got %h expected %h", obs, exp); end
      checks++;
      if (lat !== 4) begin failures++; $display("[TB] FAIL cmd_latency: got %0d expected 4", lat); end
    end
  endtask

  // Group completed while the scan lines are not one-hot
  task automatic test_bad_scan();
    int  tot [7] = '{2, 16, 16, 16, 16, 16, 16};
    int  lw  [7] = '{2, 1, 1, 1, 1, 1, 1};
    logic [63:0] b;
    ev_t exp, obs;
    int  n, lat;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin
        scan = 4'b0110;
        repeat (5) @(negedge clk);
      end
      b = {$urandom, $urandom};
      model_step(b, tot[i], lw[i], exp);
      xfer(b, tot[i], lw[i], n, obs, lat);
      checks++;
      if (n !== 1) begin failures++; $display("[TB] FAIL scan_count: got %0d expected 1", n); end
      checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL scan_event: got %h expected %h", obs, exp); end
      checks++;
      if (lat !== 4) begin failures++; $display("[TB] FAIL scan_latency: got %0d expected 4", lat); end
    end
    checks++;
    if (obs.lv !== 1'b1 || obs.row !== 2'd0 || obs.err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL scan_bad_row: got lv %b row %0d err %b expected lv 1 row 0 err 1",
               obs.lv, obs.row, obs.err);
    end
    scan = 4'b0100;
    repeat (5) @(negedge clk);
  endtask

  // Reset mid-word with LE high, released while LE stays high
  task automatic test_reset_mid_le();
    logic [63:0] b;
    ev_t exp, obs;
    int  n, lat;
    for (int i = 0; i < 8; i++) begin
      sdi = 1'($urandom);
      repeat (3) @(negedge clk);
      dclk = 1'b1;
      repeat (3) @(negedge clk);
      dclk = 1'b0;
    end
    le = 1'b1;
    repeat (3) @(negedge clk);
    dclk = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    dclk = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_idx = 0;
    for (int k = 0; k < 6; k++) m_slots[k] = 16'h0;
    ev_q.delete();
    evcyc_q.delete();
    repeat (10) @(negedge clk);
    le = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (ev_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL reset_le_quiet: got %0d pulses expected 0", ev_q.size());
    end
    b = {$urandom, $urandom};
    model_step(b, 16, 1, exp);
    xfer(b, 16, 1, n, obs, lat);
    checks++;
    if (n !== 1) begin failures++; $display("[TB] FAIL reset_le_count: got %0d expected 1", n); end
    checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL reset_le_event: got %h expected %h", obs, exp); end
    checks++;
    if (obs.widx !== 3'd0 || obs.wd !== b[15:0]) begin
      failures++;
      $display("[TB] FAIL reset_le_word: got idx %0d data %h expected idx 0 data %h", obs.widx, obs.wd, b[15:0]);
    end
  endtask

  // Random mix of data latches, bad lengths, vsyncs, commands and scan changes
  task automatic test_back_to_back();
    logic [63:0] b;
    int  r, tot, lw;
    ev_t exp, obs;
    int  n, lat;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       begin lw = 1; tot = 16; end
      else if (r == 6) begin lw = 1; tot = $urandom_range(10, 20); end
      else if (r == 7) begin lw = 2; tot = 2 + $urandom_range(0, 18); end
      else if (r == 8) begin lw = $urandom_range(3, 16); tot = lw + $urandom_range(0, 20); end
      else             begin lw = 0; tot = $urandom_range(0, 5); end
      if ($urandom_range(0, 3) == 0) begin
        scan = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'(1 << $urandom_range(0, 3));
        repeat (5) @(negedge clk);
      end
      b = {$urandom, $urandom};
      model_step(b, tot, lw, exp);
      xfer(b, tot, lw, n, obs, lat);
      checks++;
      if (n !== 1) begin failures++; $display("[TB] FAIL rand_count: got %0d expected 1", n); end
      checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL rand_event: got %h expected %h", obs, exp); end
      checks++;
      if (lat !== 4) begin failures++; $display("[TB] FAIL rand_latency: got %0d expected 4", lat); end
    end
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_group();
    test_short_word();
    test_vsync();
    test_cmd();
    test_bad_scan();
    test_reset_mid_le();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi7001_rx_decoder.md
# spi7001_rx_decoder

Receive-side decoder for the SPI7001 LED-driver serial interface (DCLK/SDI/LE plus scan lines). It oversamples the pins in the system clock domain, rebuilds 16-bit grayscale words, decodes LE-width commands, and reassembles the 96-bit per-latch data word with its scan row. It sits in the bench and in the loop-back self-test path, observing the transmitter's output pins and checking it against the SRAM frame contents.

## Interface
- WORD_W, 16, bits per grayscale word, MSB first
- WORDS_PER_LATCH, 6, words gathered into one O_latch_data (6×16 = 96)
- SYNC_STAGES, 2, synchronizer depth on every pin input (≥2)

- I_clk  in  1  system clock (50 MHz); one clock; all logic on rising edge
- I_rst  in  1  asynchronous, active-high reset
- I_dclk  in  1  serial clock pin, asynchronous to I_clk
- I_sdi  in  1  serial data pin
- I_le  in  1  latch-enable pin
- I_scan  in  4  scan1..scan4 pins, one-hot row select
- O_word_valid  out  1  one-cycle pulse, new word on O_word_data
- O_word_data  out  WORD_W  last decoded word
- O_word_idx  out  3  position of word within current latch group, 0..WORDS_PER_LATCH-1
- O_latch_valid  out  1  one-cycle pulse, full group ready
- O_latch_data  out  WORD_W*WORDS_PER_LATCH  word 0 in the MS slice
- O_latch_row  out  2  encoded I_scan at the group-completion cycle
- O_vsync  out  1  one-cycle pulse on frame-sync command
- O_cmd_valid  out  1  one-cycle pulse on any other LE command
- O_cmd_code  out  4  LE width (DCLK rises counted while LE high) for that command
- O_err  out  1  one-cycle pulse on protocol error

## Operation
- Every pin passes through SYNC_STAGES flops; edge detection compares the last sync stage with one extra delay flop.
- On a synchronized DCLK rising edge: shift sync SDI into shift register (MSB first); bit_cnt++ (saturates at 31); if sync LE = 1, le_cnt++ (saturates at 15).
- le_armed sets on a sync LE rising edge; an LE falling edge is acted on only when le_armed = 1. Clearing le_armed, bit_cnt, and le_cnt happens on every processed LE falling edge.
- Decode is driven by the LE falling edge using le_cnt:
  - le_cnt = 0: O_err.
  - le_cnt = 1: data latch. If bit_cnt ≠ WORD_W, pulse O_err and drop the word. Otherwise, pulse O_word_valid with the shift register's low WORD_W bits and O_word_idx = word_idx, store the word into slot word_idx, and increment word_idx.
  - le_cnt = 2: vsync. Pulse O_vsync and set word_idx to 0; any partial group is discarded silently.
  - le_cnt 3..15: pulse O_cmd_valid with O_cmd_code = le_cnt. Any bit count is accepted.
- Group completion: the data latch that fills slot WORDS_PER_LATCH-1 also does the following:
  - pulses O_latch_valid in the same cycle as O_word_valid;
  - drives O_latch_data with all slots;
  - wraps word_idx to 0.
- For O_latch_row, I_scan is encoded: 0001→0, 0010→1, 0100→2, 1000→3. Any other value gives row 0 and O_err in the same cycle. O_latch_valid is still asserted.
- DCLK rising edge and LE falling edge in the same I_clk cycle: the shift and counter update are applied first, and decode uses the updated counts.

## Timing
- Reset values: all outputs 0, O_latch_data 0, word_idx 0, counters 0, le_armed 0, sync flops 0.
- Input constraint: each DCLK high and low phase is ≥ 2 I_clk cycles (DCLK ≤ 12.5 MHz). SDI and LE must be stable for ≥ 2 I_clk cycles around the DCLK rise. Violations are not detected.
- Latency: pin LE falling to O_word_valid / O_vsync / O_cmd_valid / O_err = SYNC_STAGES + 2 I_clk cycles (4 at default).
- Outputs are registered.
- Data outputs hold their value until the next corresponding pulse.
- Pulses are exactly one cycle wide.
- Reset mid-word or mid-LE drops all partial state. An LE already high at reset release yields no decode until a fresh LE rising edge is seen.

## Test plan
- Six data latches, words 0x0001, 0x00FF, 0x1234, 0x8000, 0xFFFF, 0xA5A5, with I_scan = 0100.
  - Six O_word_valid pulses with idx 0..5.
  - The sixth pulse coincides with O_latch_valid, O_latch_data = 0x000100FF12348000FFFFA5A5, and O_latch_row = 2.
- 15 bits then LE width 1 → O_err, no O_word_valid, word_idx unchanged. The next correct 16-bit latch gives idx unchanged.
- Three data latches, then LE width 2 → O_vsync, no O_latch_valid. The next data latch reports O_word_idx = 0.
- LE width 5 after 48 bits → O_cmd_valid with O_cmd_code = 5; no word or error output.
- Sixth latch with I_scan = 0110 → O_latch_valid, O_latch_row = 0, O_err in the same cycle.
- Reset asserted with LE high mid-word, then released with LE still high and LE falling 10 cycles later → no outputs. The next full 16-bit latch decodes correctly with idx 0.
